// File: rtl/fpu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_stage_if
// Description : Request and response handshake bundle for fpu_issue_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_issue_stage_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [15:0] req_a_i;
    logic [15:0] req_b_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic        rsp_overflow_o;

    // Requester / response consumer side.
    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_overflow_o
    );

    // Issue stage side.
    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_stage
// Description : Registered operand stage feeding a combinational bfloat16 fpu,
//               with a show-ahead response FIFO, sticky overflow and pop count.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fpu_issue_stage_if.slave      hs,
    output logic [3:0]            fpu_op_o,
    output logic [15:0]           fpu_in1_o,
    output logic [15:0]           fpu_in2_o,
    input  wire logic [15:0]      fpu_out_i,
    input  wire logic             fpu_overflow_i,
    output logic                  sticky_ovf_o,
    input  wire logic             clr_sticky_i,
    output logic [CNT_W-1:0]      done_cnt_o,
    output logic                  busy_o
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic                r_s1_v;
    logic [3:0]          r_op;
    logic [15:0]         r_in1;
    logic [15:0]         r_in2;
    logic [16:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_done_cnt;

    logic                w_pop;
    logic                w_push;
    logic                w_accept;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign w_pop    = hs.rsp_valid_o & hs.rsp_ready_i;
    assign w_push   = r_s1_v & ((r_count < c_DEPTH) | w_pop);
    assign w_accept = hs.req_valid_i & hs.req_ready_o;

    assign hs.req_ready_o    = !rst & (!r_s1_v | w_push);
    assign hs.rsp_valid_o    = !rst & (r_count != '0);
    assign hs.rsp_data_o     = r_mem[r_rd_ptr][16:1];
    assign hs.rsp_overflow_o = r_mem[r_rd_ptr][0];

    assign fpu_op_o     = r_s1_v ? r_op : 4'b0000;
    assign fpu_in1_o    = r_in1;
    assign fpu_in2_o    = r_in2;
    assign sticky_ovf_o = r_sticky;
    assign done_cnt_o   = r_done_cnt;
    assign busy_o       = r_s1_v | (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_op       <= '0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sticky   <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_s1_v <= 1'b1;
                r_op   <= 4'b0001 << hs.req_op_i;
                r_in1  <= hs.req_a_i;
                r_in2  <= hs.req_b_i;
            end else if (w_push) begin
                r_s1_v <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase

            // A new overflow takes priority over a software clear.
            if (w_push & fpu_overflow_i) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky_i) begin
                r_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {fpu_out_i, fpu_overflow_i};
        end
    end

endmodule
`default_nettype wire
